// File: rtl/alu_share_arbiter.sv
// Purpose : round-robin share of one combinational 32-bit ALU among NREQ valid/ready requesters.
// Latency : request accepted at cycle T -> resp_valid at T+2; at least 3 cycles per operation.
// Backpr. : a stalled response (resp_ready low) holds RESP and blocks every other requester.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   req_valid/req_ready           per-requester request handshake (ready one-hot or zero)
//   req_a/req_b/req_op            packed operands / ALUControl, requester i at [32*i+:32] / [3*i+:3]
//   resp_valid/resp_ready         per-requester response handshake (valid one-hot or zero)
//   resp_result/resp_flags/resp_err  captured result, {N,Z,C,V}, illegal-opcode flag (0 outside RESP)
//   alu_a/alu_b/alu_ctrl          operands to the ALU, driven only in EXEC
//   alu_result/alu_flags          ALU outputs, captured at the end of EXEC
// Optional feature: define ALU_ILLEGAL_OP_CHECK_EN to trap opcodes 3'b101..3'b111
// (ALU sees ADD, response forced to result 0, flags 0, resp_err 1).
module alu_share_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*3-1:0]    req_op,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          resp_result,
    output logic [3:0]           resp_flags,
    output logic                 resp_err,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [2:0]           alu_ctrl,
    input  logic [31:0]          alu_result,
    input  logic [3:0]           alu_flags
);

    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_grant;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [2:0]         r_op;
    logic [31:0]        r_result;
    logic [3:0]         r_flags;
    logic               r_err;

    logic               w_found;
    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W-1:0]   w_idx;
    logic               w_accept;
    logic               w_release;
    logic               w_illegal;

`ifdef ALU_ILLEGAL_OP_CHECK_EN
    assign w_illegal = (r_op >= 3'b101);
`else
    assign w_illegal = 1'b0;
`endif

    // Round-robin search: the first valid requester at or after the pointer wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and all outputs; everything is forced to 0 while reset is held
    // so nothing leaks out before the first reset edge sets the state.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        req_ready   = '0;
        resp_valid  = '0;
        resp_result = '0;
        resp_flags  = '0;
        resp_err    = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = '0;
        if (reset_n) begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        req_ready[w_winner] = 1'b1;
                        w_accept            = 1'b1;
                        w_next              = S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_a    = r_a;
                    alu_b    = r_b;
                    alu_ctrl = w_illegal ? 3'b000 : r_op;
                    w_next   = S_RESP;
                end
                S_RESP: begin
                    resp_valid[r_grant] = 1'b1;
                    resp_result         = r_result;
                    resp_flags          = r_flags;
                    resp_err            = r_err;
                    if (resp_ready[r_grant]) begin
                        w_release = 1'b1;
                        w_next    = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr    <= '0;
            r_grant  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= w_winner;
                r_a     <= req_a[32*w_winner +: 32];
                r_b     <= req_b[32*w_winner +: 32];
                r_op    <= req_op[3*w_winner +: 3];
            end
            if (r_state == S_EXEC) begin
                r_result <= w_illegal ? 32'h0 : alu_result;
                r_flags  <= w_illegal ? 4'h0  : alu_flags;
                r_err    <= w_illegal;
            end
            // Pointer moves only on a completed response, so a dropped
            // transaction never advances the rotation.
            if (w_release) begin
                r_ptr <= (r_grant == PTR_W'(NREQ-1)) ? '0 : r_grant + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: stub ALU, table of single operations, scoreboard queue
// of expected responses, plus hand-written multi-cycle sequences (rotation, backpressure,
// reset in the middle of a response).
module tb_alu_share_arbiter;

    localparam int NREQ = 4;

    logic               clk;
    logic               reset_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*3-1:0]  req_op;
    logic [NREQ-1:0]    resp_valid;
    logic [NREQ-1:0]    resp_ready;
    logic [31:0]        resp_result;
    logic [3:0]         resp_flags;
    logic               resp_err;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [2:0]         alu_ctrl;
    logic [31:0]        alu_result;
    logic [3:0]         alu_flags;

    alu_share_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags)
    );

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        err;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    vec_t exp_q[$];
    int   grant_log[$];
    int   acc_cyc[NREQ];
    bit   prev_rv  = 1'b0;

    // Stand-in ALU: 000 ADD, 001 SUB (C = borrow), 010 AND, 011 OR, 100 XOR,
    // anything else returns result 0 / flags 0100.
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        r = '0; c = 1'b0; v = 1'b0; s = '0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                r = a - b;
                c = (a < b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: return {4'b0100, 32'h0};
        endcase
        return {r[31], (r == 32'h0), c, v, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_ctrl);

    function automatic vec_t mk(input int idx, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op, input logic [31:0] res,
                                input logic [3:0] flg, input logic err);
        vec_t v;
        v.idx = idx; v.a = a; v.b = b; v.op = op; v.res = res; v.flg = flg; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic timed_out(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, half a cycle away from the active edge.
    always @(negedge clk) begin
        int g;
        int pos;
        if (!reset_n) begin
            chk("rst_req_ready",  64'(req_ready),  64'(0));
            chk("rst_resp_valid", 64'(resp_valid), 64'(0));
            chk("rst_alu_a",      64'(alu_a),      64'(0));
            chk("rst_alu_b",      64'(alu_b),      64'(0));
            chk("rst_alu_ctrl",   64'(alu_ctrl),   64'(0));
            prev_rv = 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_cyc[i] = cyc;
                    grant_log.push_back(i);
                end
            end
            if (resp_valid != '0) begin
                chk("resp_onehot", 64'($onehot(resp_valid)), 64'(1));
                chk("resp_alu_idle", 64'({alu_a, alu_ctrl}), 64'(0));
                g = 0;
                for (int i = NREQ - 1; i >= 0; i--) if (resp_valid[i]) g = i;
                pos = -1;
                for (int k = 0; k < exp_q.size(); k++)
                    if (pos < 0 && exp_q[k].idx == g) pos = k;
                if (pos < 0) begin
                    timed_out("resp_unexpected");
                end else begin
                    chk("resp_result", 64'(resp_result), 64'(exp_q[pos].res));
                    chk("resp_flags",  64'(resp_flags),  64'(exp_q[pos].flg));
                    chk("resp_err",    64'(resp_err),    64'(exp_q[pos].err));
                    if (!prev_rv) chk("resp_latency", 64'(cyc - acc_cyc[g]), 64'(2));
                    if (resp_ready[g]) exp_q.delete(pos);
                end
                prev_rv = 1'b1;
            end else begin
                chk("idle_resp_zero", 64'({resp_result, resp_flags, resp_err}), 64'(0));
                prev_rv = 1'b0;
            end
        end
    end

    // All drivers run from posedge+1.
    task automatic issue(input vec_t v);
        req_a[32*v.idx +: 32] = v.a;
        req_b[32*v.idx +: 32] = v.b;
        req_op[3*v.idx +: 3]  = v.op;
        req_valid[v.idx]      = 1'b1;
        exp_q.push_back(v);
    endtask

    task automatic wait_accept(input int idx);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[idx] && req_valid[idx]) ok = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        if (!ok) timed_out("accept");
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) timed_out("drain");
    endtask

    task automatic wait_resp(input int idx);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (resp_valid[idx]) ok = 1'b1;
        end
        if (!ok) timed_out("resp_wait");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[9];
        logic [3:0]  ill_flg;
        logic        ill_err;
        int          n_acc;
        bit          again0;
        logic [NREQ-1:0] acc;
        int          exp_order[5];
        int          rel_cyc;

`ifdef ALU_ILLEGAL_OP_CHECK_EN
        ill_flg = 4'b0000; ill_err = 1'b1;
`else
        ill_flg = 4'b0100; ill_err = 1'b0;
`endif
        vecs[0] = mk(0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 32'h8000_0000, 4'b1001, 1'b0);
        vecs[1] = mk(2, 32'h0000_0005, 32'h0000_0005, 3'b001, 32'h0000_0000, 4'b0100, 1'b0);
        vecs[2] = mk(1, 32'hF0F0_00FF, 32'hFF00_0F0F, 3'b010, 32'hF000_000F, 4'b1000, 1'b0);
        vecs[3] = mk(3, 32'h0000_000F, 32'h8000_00F0, 3'b011, 32'h8000_00FF, 4'b1000, 1'b0);
        vecs[4] = mk(1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 32'h0000_0000, 4'b0110, 1'b0);
        vecs[5] = mk(0, 32'h0000_0003, 32'h0000_0005, 3'b001, 32'hFFFF_FFFE, 4'b1010, 1'b0);
        vecs[6] = mk(2, 32'hFFFF_FFFF, 32'h0000_00FF, 3'b100, 32'hFFFF_FF00, 4'b1000, 1'b0);
        vecs[7] = mk(3, 32'h0000_000C, 32'h0000_0022, 3'b110, 32'h0000_0000, ill_flg, ill_err);
        vecs[8] = mk(0, 32'h0000_0001, 32'h0000_0001, 3'b111, 32'h0000_0000, ill_flg, ill_err);

        // Reset held with every requester asserting valid.
        reset_n    = 1'b0;
        req_valid  = '1;
        resp_ready = '1;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        repeat (4) @(posedge clk);
        #1;
        req_valid = '0;
        reset_n   = 1'b1;
        @(posedge clk); #1;

        // Single operations from the table.
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i]);
            wait_accept(vecs[i].idx);
            wait_drain();
        end

        // All four valid straight out of reset: expect 0,1,2,3,0.
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        grant_log.delete();
        for (int i = 0; i < NREQ; i++)
            issue(mk(i, 32'(1000 + i), 32'(i), 3'b000, 32'(1000 + 2*i), 4'b0000, 1'b0));
        n_acc  = 0;
        again0 = 1'b0;
        for (int k = 0; k < 80 && !(n_acc == 5 && exp_q.size() == 0); k++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    req_valid[i] = 1'b0;
                    n_acc++;
                    if (i == 0 && !again0) begin
                        issue(mk(0, 32'd7, 32'd8, 3'b000, 32'd15, 4'b0000, 1'b0));
                        again0 = 1'b1;
                    end
                end
            end
        end
        chk("rr_accepts", 64'(n_acc), 64'(5));
        chk("rr_log_len", 64'(grant_log.size()), 64'(5));
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk($sformatf("rr_order_%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
        wait_drain();

        // Backpressure: requester 1 stalls its response for 10 cycles while 3 waits.
        grant_log.delete();
        resp_ready = 4'b1101;
        issue(mk(1, 32'h1234_0000, 32'h0000_5678, 3'b011, 32'h1234_5678, 4'b0000, 1'b0));
        issue(mk(3, 32'h0000_0010, 32'h0000_0001, 3'b001, 32'h0000_000F, 4'b0000, 1'b0));
        wait_accept(1);
        wait_resp(1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_req_ready", 64'(req_ready), 64'(0));
            chk("bp_resp_valid", 64'(resp_valid), 64'(4'b0010));
        end
        @(posedge clk); #1;
        rel_cyc = cyc;
        resp_ready = '1;
        wait_accept(3);
        wait_drain();
        chk("bp_accept_cycle", 64'(acc_cyc[3]), 64'(rel_cyc + 1));
        chk("bp_grant_last", 64'(grant_log[grant_log.size()-1]), 64'(3));

        // Reset while requester 2 sits in RESP; pointer is 2 beforehand.
        issue(mk(1, 32'd2, 32'd3, 3'b000, 32'd5, 4'b0000, 1'b0));
        wait_accept(1);
        wait_drain();
        resp_ready = 4'b1011;
        issue(mk(2, 32'd9, 32'd4, 3'b001, 32'd5, 4'b0000, 1'b0));
        wait_accept(2);
        wait_resp(2);
        @(posedge clk); #1;
        reset_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        reset_n    = 1'b1;
        resp_ready = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_resp", 64'(resp_valid), 64'(0));
        end
        @(posedge clk); #1;
        grant_log.delete();
        issue(mk(3, 32'd40, 32'd2, 3'b000, 32'd42, 4'b0000, 1'b0));
        issue(mk(1, 32'd50, 32'd8, 3'b001, 32'd42, 4'b0000, 1'b0));
        wait_accept(1);
        wait_accept(3);
        wait_drain();
        chk("post_rst_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(1));

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
